uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter between N_REQ byte requesters using round-robin arbitration.
//  Each grant may carry a burst of up to MAX_BURST consecutive bytes from the same requester.
//  Sits between client logic (command responders, debug streams) and a uart_tx core.
//  A watchdog aborts any transfer the transmitter fails to complete.
// PARAMETERS
//  N_REQ       4      number of requesters, 2..8
//  MAX_BURST   4      max consecutive bytes per grant, >=1
//  TIMEOUT_CYC 20000  cycles to wait for i_tx_done before abort; set > 10*CLK_PER_BIT of the tx core
// PORTS
//  clk         in   1        system clock, all logic on posedge
//  i_rst       in   1        synchronous reset, active-high
//  i_req       in   N_REQ    per-requester byte-pending flag, level; held until acked
//  i_data      in   8*N_REQ  byte for requester k on i_data[8k+7:8k]; stable while i_req[k]=1
//  o_ack       out  N_REQ    one-hot, 1-cycle pulse: byte of that requester consumed
//  o_tx_start  out  1        1-cycle pulse to the tx core: load o_tx_data and send
//  o_tx_data   out  8        byte to transmit; held stable until the next start
//  i_tx_busy   in   1        tx core is shifting a frame
//  i_tx_done   in   1        1-cycle pulse from the tx core at end of stop bit
//  o_owner     out  3        index of the current/last granted requester
//  o_busy      out  1        high in S_WAIT and S_NEXT
//  o_err       out  1        1-cycle pulse on watchdog abort
// BEHAVIOUR
//  All outputs are registered.
//  Reset values:
//   - o_ack=0, o_tx_start=0, o_tx_data=0, o_owner=0, o_busy=0, o_err=0
//   - rr pointer last=N_REQ-1, so requester 0 wins first
//   - burst_cnt=0, wd_cnt=0, state=S_IDLE
//  Reset mid-transfer: returns to S_IDLE at once; the tx frame in flight is not tracked.
//  Arbitration: the winner is the first k with i_req[k]=1, scanning last+1, last+2, ... mod N_REQ.
//  Issue action (edge E):
//   - o_tx_data <= i_data[winner], o_owner <= winner
//   - during the cycle after E: o_tx_start=1, o_ack[winner]=1
//  States:
//   - S_IDLE: if |i_req && !i_tx_busy, issue to the rr winner, burst_cnt<=1, wd_cnt<=0, go S_WAIT.
//     Latency: req seen at edge E gives start/ack high in cycle E+1.
//   - S_WAIT: wd_cnt increments each cycle.
//     - On i_tx_done, go S_NEXT.
//     - Else if wd_cnt==TIMEOUT_CYC-1: o_err pulse, last<=owner, burst_cnt<=0, go S_IDLE.
//   - S_NEXT (one cycle):
//     - If i_req[owner] && burst_cnt<MAX_BURST && !i_tx_busy: issue to owner, burst_cnt+1, wd_cnt<=0, go S_WAIT.
//     - Otherwise: last<=owner, burst_cnt<=0, go S_IDLE. S_IDLE arbitrates in the following cycle.
//  Boundary and ordering rules:
//   - Requests deasserted before ack are dropped silently; no ack is generated.
//   - Requests arriving during S_WAIT/S_NEXT wait; they never preempt a burst.
//   - i_tx_done in the same cycle as the watchdog terminal count: done wins and no o_err.
//   - i_tx_done outside S_WAIT is ignored.
//   - i_tx_busy high in S_IDLE blocks issue; the pointer does not move.
//   - Pointer wraps from N_REQ-1 to 0.
//   - MAX_BURST=1 gives pure per-byte round-robin.
//   - burst_cnt width is $clog2(MAX_BURST+1).
//  o_busy=1 exactly when state is S_WAIT or S_NEXT.
// TESTING
//  Run with a tx core model where done follows start after 100 cycles.
//  1. Reset, i_req=4'b0001, data0=8'hA5
//     -> start+ack[0] one cycle later; o_tx_data=A5; after MAX_BURST(4) bytes, req0 must release or wait for rearbitration.
//  2. i_req=4'b1111 held, MAX_BURST=4
//     -> grant order 0,0,0,0,1,1,1,1,2,...,3; then wraps to 0.
//  3. MAX_BURST=1, i_req=4'b0101 held
//     -> start sequence owner 0,2,0,2; o_owner matches each ack.
//  4. Done never pulses, TIMEOUT_CYC=50
//     -> o_err pulse 50 cycles after start; S_IDLE; next grant goes to the next requester.
//  5. i_rst asserted in S_WAIT
//     -> next cycle all outputs zero; requester 0 served first after release.
//  6. req1 drops before ack while i_tx_busy=1
//     -> no ack[1], no start; o_busy stays 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte requesters.
// A grant may carry a burst of up to MAX_BURST bytes from the same requester; a
// watchdog abandons any frame the transmitter fails to finish within TIMEOUT_CYC.
module uart_tx_arbiter #(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned MAX_BURST   = 4,
   parameter int unsigned TIMEOUT_CYC = 20000
) (
   input  logic               clk,
   input  logic               i_rst,
   input  logic [N_REQ-1:0]   i_req,
   input  logic [8*N_REQ-1:0] i_data,
   output logic [N_REQ-1:0]   o_ack,
   output logic               o_tx_start,
   output logic [7:0]         o_tx_data,
   input  logic               i_tx_busy,
   input  logic               i_tx_done,
   output logic [2:0]         o_owner,
   output logic               o_busy,
   output logic               o_err
);

   localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned BW = $clog2(MAX_BURST + 1);
   localparam int unsigned WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StNext} state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   last_q, last_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [BW-1:0]   burst_q, burst_d;
   logic [WW-1:0]   wd_q, wd_d;
   logic [7:0]      data_q, data_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic            start_q, start_d;
   logic            err_q, err_d;
   logic            busy_q, busy_d;

   logic [IW-1:0]   win_idx;
   logic [IW-1:0]   sel_idx;
   logic [7:0]      sel_data;
   logic            issue;

   // Round-robin winner: scan last+1 .. last+N_REQ; reverse order so the nearest request wins.
   always_comb begin
      int unsigned idx;
      logic [IW-1:0] cand;
      win_idx = '0;
      idx     = 0;
      cand    = '0;
      for (int unsigned i = N_REQ; i > 0; i--) begin
         idx  = (32'(last_q) + i) % N_REQ;
         cand = IW'(idx);
         if (i_req[cand]) win_idx = cand;
      end
   end

   // A burst continuation re-serves the owner; otherwise the fresh arbitration winner.
   assign sel_idx  = (state_q == StNext) ? owner_q : win_idx;
   assign sel_data = i_data[{sel_idx, 3'b000} +: 8];

   // Next-state and registered-output values.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      owner_d = owner_q;
      burst_d = burst_q;
      wd_d    = wd_q;
      data_d  = data_q;
      ack_d   = '0;
      start_d = 1'b0;
      err_d   = 1'b0;
      issue   = 1'b0;

      case (state_q)
         StIdle: begin
            if (|i_req && !i_tx_busy) begin
               issue   = 1'b1;
               burst_d = BW'(1);
            end
         end
         StWait: begin
            wd_d = wd_q + 1'b1;
            // Done takes priority over a coincident watchdog terminal count.
            if (i_tx_done) begin
               state_d = StNext;
            end else if (wd_q == WW'(TIMEOUT_CYC - 1)) begin
               err_d   = 1'b1;
               last_d  = owner_q;
               burst_d = '0;
               state_d = StIdle;
            end
         end
         StNext: begin
            if (i_req[owner_q] && (burst_q < BW'(MAX_BURST)) && !i_tx_busy) begin
               issue   = 1'b1;
               burst_d = burst_q + 1'b1;
            end else begin
               last_d  = owner_q;
               burst_d = '0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (issue) begin
         state_d        = StWait;
         wd_d           = '0;
         owner_d        = sel_idx;
         data_d         = sel_data;
         start_d        = 1'b1;
         ack_d[sel_idx] = 1'b1;
      end

      busy_d = (state_d == StWait) || (state_d == StNext);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q <= StIdle;
         last_q  <= IW'(N_REQ - 1);
         owner_q <= '0;
         burst_q <= '0;
         wd_q    <= '0;
         data_q  <= '0;
         ack_q   <= '0;
         start_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         burst_q <= burst_d;
         wd_q    <= wd_d;
         data_q  <= data_d;
         ack_q   <= ack_d;
         start_q <= start_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   assign o_ack      = ack_q;
   assign o_tx_start = start_q;
   assign o_tx_data  = data_q;
   assign o_owner    = 3'(owner_q);
   assign o_busy     = busy_q;
   assign o_err      = err_q;

endmodule
